uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver: recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from an asynchronous `rx` line and delivers bytes on a valid/ready stream. It is the receive-side counterpart of the team's UART transmitter and pairs with it in loopback and host links. Sampling is mid-bit, derived from a per-bit clock count. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 16: clocks per serial bit; must be even and ≥ 4.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two ≥ 2; used only with `UART_RX_FIFO_EN`.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  asynchronous serial input, idle high.
- `data`  out  8  received byte; valid while `valid` = 1.
- `valid`  out  1  byte available.
- `ready`  in  1  consumer accepts the byte when `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because storage was full.

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1) to give `rx_s`. A further register holds `rx_s` from the previous cycle.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- FSM states:
  - **IDLE**: detect a 1→0 transition of `rx_s`. On detection: `cnt`←0, go to START.
  - **START**: when `cnt == CLKS_PER_BIT/2-1`, sample `rx_s`.
    - 0: `cnt`←0, `idx`←0, go to DATA.
    - 1: false start (glitch); go to IDLE with no output.
  - **DATA**: when `cnt == CLKS_PER_BIT-1`, sample `rx_s` into `sh[idx]` (LSB first) and set `cnt`←0.
    - After `idx == 7`, go to STOP; otherwise `idx`++.
  - **STOP**: when `cnt == CLKS_PER_BIT-1`, sample `rx_s`.
    - 1: push `sh` to storage.
    - 0: pulse `frame_err` and discard the byte.
    - Either way, go to IDLE. Because IDLE needs a 1→0 edge, a held-low (break) line produces no further frames until `rx` returns high.
- Storage without `UART_RX_FIFO_EN`: a single holding register.
  - Push while empty, or push in the same cycle as a pop: load the new byte; `valid` stays or becomes 1.
  - Push while full and no pop: pulse `overrun`; the old byte is retained.
- `data` is stable while `valid && !ready`.
- **Reset, including mid-frame**: FSM←IDLE, `cnt`, `idx` and `sh` ← 0, synchronizer ← 1, storage emptied.
  - `valid`, `frame_err` and `overrun` = 0; `data` = 0x00.

## Timing
- Pin-to-`rx_s` latency: 2 cycles.
- Let `t` be the first cycle in which `rx_s` = 0 and the previous `rx_s` = 1. All samples are relative to `t`:
  - Start sample: `t + CLKS_PER_BIT/2`.
  - Data bit `i` sample: `t + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT`.
  - Stop sample: `t + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
- `valid` (or `frame_err`) rises in the cycle after the stop sample. For `CLKS_PER_BIT` = 16: stop sample at t+152, `valid` at t+153.
- `frame_err` and `overrun` assert in the same cycle the push would have occurred.
- Back-to-back frames: a start edge is accepted from the first cycle after the stop sample.
- `valid` falls in the cycle after a pop, unless a push occurs in the same cycle as the pop or storage still holds entries.

## Configuration
- `UART_RX_FIFO_EN` defined: storage is a `FIFO_DEPTH`-entry FIFO.
  - `data` shows the head entry.
  - `overrun` pulses only when the FIFO is full and there is no pop in that cycle.
  - Simultaneous push and pop while full is lossless.
- Not defined: single holding register as described in Operation; `FIFO_DEPTH` is ignored.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- Frame 0x55 with `ready` = 1 → `valid` high for exactly 1 cycle at t+153 with `data` = 0x55; `frame_err` = 0, `overrun` = 0.
- `rx` low for 4 cycles, then high → no `valid` and no `frame_err`; FSM back in IDLE. A following frame 0xC3 is received correctly.
- Frame 0xA3 with stop bit 0 → one `frame_err` pulse and no `valid`. `rx` held low 40 more cycles, then high, then frame 0x3C → only 0x3C is delivered.
- `ready` = 0, frames 0x11 then 0x22:
  - Without the macro: `overrun` pulses at the second stop, and `data` stays 0x11.
  - With the macro and `FIFO_DEPTH` = 4: 5 frames 0x01..0x05 → `overrun` pulses on the 5th. Raising `ready` then pops 0x01..0x04 in order.
- `rst` pulsed 1 cycle mid-DATA of frame 0x99 → `valid` = 0 and storage empty. The next full frame 0x7E is received correctly with no spurious output.
- Byte 0x10 pending with `ready` held 0; raise `ready` exactly in the push cycle of frame 0x20 → 0x10 accepted, `data` = 0x20, `valid` stays 1, and no `overrun`.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte stream output.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
        $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, rx_s_q, rx_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        sh_q, sh_d;
    logic              push;
    logic              pop;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        sh_d        = sh_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q && rx_prev_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s_q) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    sh_d[idx_q] = rx_s_q;
                    cnt_d       = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    // A low stop bit drops the byte; IDLE then waits for a fresh falling edge.
                    if (rx_s_q) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign pop       = valid && ready;

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             do_push;

    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign do_push = push && (!full || pop);
    assign valid   = (count_q != '0);
    assign data    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= sh_q;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            count_q   <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
            overrun_q <= push && full && !pop;
        end
    end
`else
    logic [7:0] data_q;
    logic       valid_q;

    assign valid = valid_q;
    assign data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && valid_q && !pop;
            if (push && (!valid_q || pop)) begin
                data_q  <= sh_q;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level event model plus directed literal checks.
// Build with UART_RX_FIFO_EN defined to exercise the FIFO storage variant.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        bit         err;
        logic [7:0] b;
    } ev_t;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    ev_t        sched[$];
    ev_t        ev;
    logic [7:0] mq[$];
    bit         m_ferr = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_pop, m_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame-level model: a frame whose line falls in cycle p completes (byte or error) at p+155.
    always @(posedge clk) begin
        cyc    = cyc + 1;
        m_pop  = (mq.size() > 0) && ready;
        m_full = (mq.size() == CAP);
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (rst) begin
            mq.delete();
            sched.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (sched.size() > 0 && sched[0].at == cyc) begin
                ev = sched.pop_front();
                if (ev.err) m_ferr = 1'b1;
                else if (m_full && !m_pop) m_ovr = 1'b1;
                else mq.push_back(ev.b);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("valid", valid, mq.size() != 0);
            if (mq.size() != 0) chk("data", data, mq[0]);
            chk("frame_err", frame_err, m_ferr);
            chk("overrun", overrun, m_ovr);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        ev_t e;
        @(posedge clk);
        #1;
        e.at  = cyc + 155;
        e.err = !stop;
        e.b   = b;
        sched.push_back(e);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = stop;
        hold(CPB);
        if (stop) rx = 1'b1;
    endtask

    initial begin
        logic [7:0] partial;
        // reset
        hold(3);
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        hold(5);

        // 0x55, ready high: valid exactly one cycle at t+153
        ready = 1'b1;
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                chk("lit55_before", valid, 1'b0);
                @(negedge clk);
                chk("lit55_valid", valid, 1'b1);
                chk("lit55_data", data, 8'h55);
                @(negedge clk);
                chk("lit55_after", valid, 1'b0);
            end
        join
        hold(5);

        // glitch of 4 cycles, then a real frame
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(30);
        chk("glitch_novalid", valid, 1'b0);
        send_frame(8'hC3, 1'b1);
        hold(5);

        // framing error, held break, then a clean frame
        fork
            send_frame(8'hA3, 1'b0);
            begin
                repeat (156) @(posedge clk);
                @(negedge clk);
                chk("lit_ferr", frame_err, 1'b1);
                chk("lit_ferr_novalid", valid, 1'b0);
            end
        join
        hold(40);
        rx = 1'b1;
        hold(8);
        send_frame(8'h3C, 1'b1);
        hold(5);

        // storage full with ready low
        ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b1);
            hold(3);
        end
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (156) @(posedge clk);
                @(negedge clk);
                chk("lit_ovr_fifo", overrun, 1'b1);
            end
        join
        hold(3);
        chk("lit_fifo_head", data, 8'h01);
        ready = 1'b1;
        hold(8);
        chk("lit_fifo_drained", valid, 1'b0);
`else
        send_frame(8'h11, 1'b1);
        hold(3);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (156) @(posedge clk);
                @(negedge clk);
                chk("lit_ovr", overrun, 1'b1);
                chk("lit_ovr_data", data, 8'h11);
            end
        join
        hold(3);
        chk("lit_keep_data", data, 8'h11);
        chk("lit_keep_valid", valid, 1'b1);
        ready = 1'b1;
        hold(4);
`endif

        // reset in the middle of the data bits of 0x99
        partial = 8'h99;
        @(posedge clk);
        #1;
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            hold(CPB);
        end
        rst = 1'b1;
        rx  = 1'b1;
        hold(1);
        rst = 1'b0;
        chk("lit_midrst_valid", valid, 1'b0);
        hold(20);
        send_frame(8'h7E, 1'b1);
        hold(5);

        // pending 0x10, ready raised exactly in the push cycle of 0x20
        ready = 1'b0;
        send_frame(8'h10, 1'b1);
        hold(3);
        fork
            send_frame(8'h20, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                ready = 1'b1;
                @(negedge clk);
                chk("lit_pend_data", data, 8'h10);
                @(negedge clk);
                chk("lit_swap_valid", valid, 1'b1);
                chk("lit_swap_data", data, 8'h20);
                chk("lit_swap_ovr", overrun, 1'b0);
            end
        join
        hold(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
